// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the instruction-fetch, load/store and byte-wide RAM
// signals of mem_ctrl into one interface.
//   slave  modport: the controller side (mem_ctrl).
//   master modport: the initiators plus the RAM (the testbench or the
//                   surrounding core).
// Signals:
//   if_req/if_addr         fetch request and byte address
//   if_done/if_data        fetch done pulse and fetched word
//   mem_req/mem_we/mem_len load/store request, direction, size code
//   mem_addr/mem_wdata     load/store byte address and store data
//   mem_done/mem_rdata     load/store done pulse and load data
//   mem_busy               mem_req & ~mem_done
//   ram_a/ram_dout/ram_wr  registered RAM address, write data, write strobe
//   ram_din                RAM read data for the address of the previous cycle
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              mem_busy;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, mem_busy, ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, mem_busy, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller. Serves the IF-stage fetch and the
// MEM-stage load/store initiators over one 8-bit synchronous RAM port with
// 1-cycle read latency. Words are little-endian; loads are zero-extended.
// Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous, active-low reset
//   bus  mem_ctrl_if.slave (fetch, load/store and RAM signals)
// The load/store initiator wins when both request in IDLE. The FSM never
// accepts a request in the cycle its done pulse is high, so there is always
// one IDLE cycle after a done before the next request is taken.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt;      // cycle index within the transaction (1 = first RAM cycle)
  logic [2:0]  nbytes;   // transfer length N
  logic [31:0] wbuf;     // captured store data
  logic [31:0] rbuf;     // load assembly buffer, cleared on accept
  logic [31:0] rd_word;  // rbuf with the byte arriving this cycle merged in
  logic [1:0]  bidx;     // index of the byte on ram_din (cnt - 2)

  logic accept_if, accept_mem, rd_sample, rd_finish, wr_last;

  assign bus.mem_busy = bus.mem_req & ~bus.mem_done;

  assign bidx = cnt[1:0] - 2'd2;

  always_comb begin
    rd_word = rbuf;
    rd_word[{bidx, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    accept_if  = 1'b0;
    accept_mem = 1'b0;
    rd_sample  = 1'b0;
    rd_finish  = 1'b0;
    wr_last    = 1'b0;
    case (state)
      IDLE: begin
        if (!(bus.if_done | bus.mem_done)) begin
          if (bus.mem_req) begin
            accept_mem = 1'b1;
            state_n    = bus.mem_we ? MEM_WR : MEM_RD;
          end else if (bus.if_req) begin
            accept_if = 1'b1;
            state_n   = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        // Read data trails the address by one cycle, so byte k lands in cycle k+2.
        rd_sample = (cnt >= 3'd2);
        rd_finish = (cnt == nbytes + 3'd1);
        if (rd_finish) state_n = IDLE;
      end
      MEM_WR: begin
        wr_last = (cnt == nbytes);
        if (wr_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      nbytes        <= '0;
      wbuf          <= '0;
      rbuf          <= '0;
      bus.ram_a     <= '0;
      bus.ram_dout  <= '0;
      bus.ram_wr    <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.if_data   <= '0;
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      if (accept_if) begin
        bus.ram_a <= bus.if_addr;
        cnt       <= 3'd1;
        nbytes    <= 3'd4;
        rbuf      <= '0;
      end else if (accept_mem) begin
        bus.ram_a <= bus.mem_addr;
        cnt       <= 3'd1;
        rbuf      <= '0;
        case (bus.mem_len)
          2'd0:    nbytes <= 3'd1;
          2'd1:    nbytes <= 3'd2;
          default: nbytes <= 3'd4;
        endcase
        if (bus.mem_we) begin
          wbuf         <= bus.mem_wdata;
          bus.ram_dout <= bus.mem_wdata[7:0];
          bus.ram_wr   <= 1'b1;
        end
      end else if (state != IDLE) begin
        cnt <= cnt + 3'd1;
        if (cnt < nbytes) begin
          bus.ram_a <= bus.ram_a + ADDR_W'(1);
          if (state == MEM_WR) bus.ram_dout <= wbuf[{cnt[1:0], 3'b000} +: 8];
        end
        if (rd_sample) rbuf <= rd_word;
        if (rd_finish) begin
          if (state == IF_RD) begin
            bus.if_data <= rd_word;
            bus.if_done <= 1'b1;
          end else begin
            bus.mem_rdata <= rd_word;
            bus.mem_done  <= 1'b1;
          end
        end
        if (wr_last) begin
          bus.ram_wr   <= 1'b0;
          bus.mem_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte RAM with 1-cycle read
// latency sits on the RAM port; a separate reference byte map holds what memory
// should contain, and expected words, RAM-port activity and done timing are
// derived from the transfer rules (N bytes, done at N+2 for reads, N+1 for
// writes, addresses addr+k modulo 2^32).
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    bus.ram_din <= ram_rd(bus.ram_a);
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] ka;
      ka = a + 32'(k);
      w[8*k +: 8] = ref_mem.exists(ka) ? ref_mem[ka] : 8'h00;
    end
    return w;
  endfunction

  always @(negedge clk)
    if (rst === 1'b1) chk("done_overlap", 32'(bus.if_done & bus.mem_done), 32'd0);

  // Starts a request one negedge after the call and returns at the negedge of
  // its done cycle with the request dropped.
  task automatic do_txn(input bit is_if, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n, dc;
    logic [31:0] exp_w, prev_if, prev_mem, ea;
    n  = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    dc = (!is_if && we) ? n + 1 : n + 2;
    @(negedge clk);
    prev_if  = bus.if_data;
    prev_mem = bus.mem_rdata;
    if (is_if) begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end else begin
      bus.mem_addr  = addr;
      bus.mem_we    = we;
      bus.mem_len   = len;
      bus.mem_wdata = wdata;
      bus.mem_req   = 1'b1;
    end
    exp_w = ref_word(addr, n);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (c <= n) begin
        ea = addr + 32'(c - 1);
        chk("ram_a", bus.ram_a, ea);
        chk("ram_wr", 32'(bus.ram_wr), 32'(!is_if && we));
        if (!is_if && we) chk("ram_dout", 32'(bus.ram_dout), 32'(wdata[8*(c-1) +: 8]));
      end
      chk("if_done", 32'(bus.if_done), 32'(is_if && c == dc));
      chk("mem_done", 32'(bus.mem_done), 32'(!is_if && c == dc));
      chk("mem_busy", 32'(bus.mem_busy), 32'(!is_if && c != dc));
    end
    if (is_if) begin
      chk("if_data", bus.if_data, exp_w);
      chk("mem_rdata_hold", bus.mem_rdata, prev_mem);
      bus.if_req = 1'b0;
    end else begin
      if (we) begin
        chk("ram_wr_end", 32'(bus.ram_wr), 32'd0);
        for (int k = 0; k < n; k++) begin
          ea = addr + 32'(k);
          ref_mem[ea] = wdata[8*k +: 8];
          chk("ram_content", 32'(ram_rd(ea)), 32'(ref_mem[ea]));
        end
      end else begin
        chk("mem_rdata", bus.mem_rdata, exp_w);
      end
      chk("if_data_hold", bus.if_data, prev_if);
      bus.mem_req = 1'b0;
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w;
    bit          is_if, we;
    logic [1:0]  len;

    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    for (int i = 0; i < 64; i++) preload(32'h200 + 32'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) preload(32'hFFFF_FFF8 + 32'(i), 8'($urandom));

    repeat (3) @(negedge clk);
    chk("rst_ram_a", bus.ram_a, 32'd0);
    chk("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_if_done", 32'(bus.if_done), 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
    chk("rst_mem_busy", 32'(bus.mem_busy), 32'd0);
    rst = 1'b1;

    // Word load at 0x100 -> 0x44332211, done in cycle 6
    do_txn(1'b0, 1'b0, 2'd2, 32'h100, '0);
    chk("t1_word", bus.mem_rdata, 32'h4433_2211);
    // Byte store at 0x7
    do_txn(1'b0, 1'b1, 2'd0, 32'h7, 32'hDEAD_BEEF);
    chk("t2_byte", 32'(ram_rd(32'h7)), 32'h0000_00EF);
    // Half load across the address wrap
    do_txn(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, '0);
    chk("t4_upper", 32'(bus.mem_rdata[31:16]), 32'd0);

    // Simultaneous requests: MEM first, IF accepted the cycle after mem_done
    @(negedge clk);
    bus.if_addr = 32'h208; bus.if_req = 1'b1;
    bus.mem_addr = 32'h204; bus.mem_we = 1'b0; bus.mem_len = 2'd2; bus.mem_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("t3_mem_done", 32'(bus.mem_done), 32'(c == 6));
      chk("t3_if_wait", 32'(bus.if_done), 32'd0);
    end
    chk("t3_mem_rdata", bus.mem_rdata, ref_word(32'h204, 4));
    bus.mem_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t3_if_done", 32'(bus.if_done), 32'(c == 7));
      chk("t3_mem_idle", 32'(bus.mem_done), 32'd0);
    end
    chk("t3_if_data", bus.if_data, ref_word(32'h208, 4));
    bus.if_req = 1'b0;

    // Back-to-back fetches with if_req held: done at cycles 6 and 13
    @(negedge clk);
    bus.if_addr = 32'h210; bus.if_req = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk("t6_if_done", 32'(bus.if_done), 32'(c == 6 || c == 13));
      chk("t6_mem_busy", 32'(bus.mem_busy), 32'd0);
      if (c == 6) begin
        chk("t6_first", bus.if_data, ref_word(32'h210, 4));
        bus.if_addr = 32'h214;
      end
    end
    chk("t6_second", bus.if_data, ref_word(32'h214, 4));
    bus.if_req = 1'b0;

    // Reset during cycle 2 of a word store
    @(negedge clk);
    bus.mem_addr = 32'h5000; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_wdata = 32'hCAFE_F00D; bus.mem_req = 1'b1;
    @(negedge clk);
    chk("t5_wr_active", 32'(bus.ram_wr), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("t5_ram_a", bus.ram_a, 32'd0);
    chk("t5_ram_dout", 32'(bus.ram_dout), 32'd0);
    chk("t5_mem_done", 32'(bus.mem_done), 32'd0);
    chk("t5_if_data", bus.if_data, 32'd0);
    chk("t5_mem_rdata", bus.mem_rdata, 32'd0);
    bus.mem_req = 1'b0;
    #1;
    chk("t5_mem_busy", 32'(bus.mem_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_no_done", 32'(bus.mem_done), 32'd0);
      chk("t5_no_wr", 32'(bus.ram_wr), 32'd0);
    end
    do_txn(1'b1, 1'b0, 2'd2, 32'h100, '0);

    // Random mix of fetches, loads and stores
    for (int i = 0; i < 40; i++) begin
      is_if = ($urandom_range(0, 9) < 3);
      we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      len   = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                          : 32'h200 + 32'($urandom_range(0, 59));
      w     = $urandom;
      do_txn(is_if, we, len, a, w);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
